sort_sequencer: RTL and testbench
=================================

Name: sort_sequencer

Overview:
- Sequential sorting engine for CNN pooling and top-k paths. It accepts one packed vector of NUM_VALS unsigned words and orders it descending, so lane 0 holds the maximum.
- Uses a single rank of compare-swap units, reused over NUM_VALS odd-even transposition phases, instead of a fully unrolled combinational network.
- Has a valid/ready handshake on both input and output.

Parameters:
- NUM_VALS, 8, number of words per vector; must be at least 2.
- SIZE, 8, width in bits of each unsigned word.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is presented.
- in_ready  output  1  block can accept a vector.
- in_data  input  NUM_VALS*SIZE  packed input; lane k = bits [k*SIZE +: SIZE].
- out_valid  output  1  out_data holds a sorted result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  NUM_VALS*SIZE  sorted vector; lane 0 = largest.
- busy  output  1  high while in the SORT state.

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state IDLE, buffer all zeros, phase counter 0;
  - in_ready=0 during the reset cycle, then 1 in IDLE;
  - out_valid=0, out_data=0, busy=0.
- FSM states: IDLE, SORT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at edge T: load in_data into the buffer, clear the phase counter, go to SORT.
- SORT:
  - in_ready=0, busy=1.
  - Each cycle executes one phase p = 0..NUM_VALS-1.
  - Even p compares pairs (0,1),(2,3),...; odd p compares pairs (1,2),(3,4),....
  - A lane with no partner in a phase is left unchanged.
  - Swap when lane k < lane k+1 (unsigned). Equal values never swap.
  - After phase NUM_VALS-1, go to DONE.
  - Phases run at edges T+1..T+NUM_VALS; out_valid=1 from cycle T+NUM_VALS+1.
- DONE:
  - out_valid=1; out_data = buffer, held stable while out_ready=0.
  - On out_ready=1: go to IDLE. in_ready rises the following cycle; there is no same-cycle turnaround.
- Throughput: at most one vector per NUM_VALS+2 cycles with out_ready tied high.
- Ordering: the result is a permutation of the input; multiset preserved, including duplicates and all-zero or all-ones vectors.
- Boundaries:
  - in_valid while not in IDLE is ignored; the producer must hold it.
  - out_ready outside DONE is ignored.
  - rst asserted during SORT or DONE aborts immediately and discards the result; no partial output.
  - NUM_VALS=2: odd phases are no-ops.
- out_data is registered directly from the buffer; no combinational path from in_data to out_data.

Optional Feature:
- Macro: SORT_EARLY_EXIT_EN.
- When defined:
  - The block counts swaps per phase.
  - After two consecutive phases with zero swaps (minimum 2 phases), it moves to DONE at the next edge, skipping the remaining phases.
  - Earliest out_valid is cycle T+3.
  - Results are identical to the full run.
- When undefined: always exactly NUM_VALS phases; fixed latency.

Test Plan (NUM_VALS=8, SIZE=8):
- Lanes 0..7 = {1,2,3,4,5,6,7,8}, in_valid at T → out_data lanes {8,7,6,5,4,3,2,1}; out_valid first high at T+9; busy high T+1..T+8.
- Lanes {200,200,3,3,255,0,17,17} → {255,200,200,17,17,3,3,0}.
- Already-descending {9,8,7,6,5,4,3,2} → output unchanged.
  - Without SORT_EARLY_EXIT_EN: out_valid at T+9.
  - With it: out_valid at T+3.
- out_ready held 0 for 5 cycles in DONE → out_data and out_valid stable; in_ready stays 0; second in_valid is not accepted until the cycle after out_ready=1.
- rst=1 at T+4 mid-sort → next cycle shows IDLE, out_valid=0, out_data=0, busy=0; a new vector {0,..,0,255} then sorts to {255,0,...,0}.
- 1000 random vectors with random out_ready back-pressure → each output equals the reference descending sort; no lost or duplicated vectors.

Source files
------------

// File: rtl/sort_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sort_sequencer_if
//  Description : Handshake bundle for sort_sequencer. It carries the input
//                vector channel, the sorted output channel and the busy flag.
//                The master side is the producer/consumer and the slave side
//                is the sorter.
//  Revision    : 1.0  initial release
// ============================================================================
interface sort_sequencer_if #(
    parameter int NUM_VALS = 8,
    parameter int SIZE     = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_VALS*SIZE-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_VALS*SIZE-1:0] out_data;
    logic                     busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/sort_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sort_sequencer
//  Description : Sequential descending sorter. A single rank of compare-swap
//                units is reused over NUM_VALS odd-even transposition phases,
//                one phase per clock. Lane 0 of the result holds the maximum.
//                Optional macro SORT_EARLY_EXIT_EN: finish as soon as two
//                consecutive phases perform no swap.
//  Revision    : 1.0  initial release
// ============================================================================
module sort_sequencer #(
    parameter int NUM_VALS = 8,
    parameter int SIZE     = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    sort_sequencer_if.slave  bus
);

    localparam int              c_W    = NUM_VALS * SIZE;
    localparam int              c_PW   = $clog2(NUM_VALS);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(NUM_VALS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SORT = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [c_W-1:0]      r_buf;
    logic [c_PW-1:0]     r_phase;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;

    logic [SIZE-1:0]     w_lane [NUM_VALS];
    logic [NUM_VALS-2:0] w_swap;
    logic [c_W-1:0]      w_next;
    logic                w_odd;
    logic                w_exit;

    // Even phases pair lanes (0,1),(2,3)..; odd phases pair (1,2),(3,4)..
    assign w_odd = r_phase[0];

    genvar k;
    generate
        for (k = 0; k < NUM_VALS; k++) begin : g_lane
            assign w_lane[k] = r_buf[k*SIZE +: SIZE];
        end

        // A pair swaps only when it belongs to the current phase and the
        // lower lane is strictly smaller; equal values stay put.
        for (k = 0; k < NUM_VALS - 1; k++) begin : g_pair
            if ((k % 2) == 0) begin : g_even
                assign w_swap[k] = !w_odd && (w_lane[k] < w_lane[k+1]);
            end else begin : g_odd
                assign w_swap[k] = w_odd && (w_lane[k] < w_lane[k+1]);
            end
        end

        // Active pairs in one phase are disjoint, so each lane takes at most
        // one neighbour; lanes without a partner keep their value.
        for (k = 0; k < NUM_VALS; k++) begin : g_next
            if (k == 0) begin : g_first
                assign w_next[k*SIZE +: SIZE] = w_swap[k] ? w_lane[k+1] : w_lane[k];
            end else if (k == NUM_VALS - 1) begin : g_last
                assign w_next[k*SIZE +: SIZE] = w_swap[k-1] ? w_lane[k-1] : w_lane[k];
            end else begin : g_mid
                assign w_next[k*SIZE +: SIZE] = w_swap[k-1] ? w_lane[k-1] :
                                                w_swap[k]   ? w_lane[k+1] : w_lane[k];
            end
        end
    endgenerate

`ifdef SORT_EARLY_EXIT_EN
    // An even phase followed by an odd phase with no swap means the vector
    // is already ordered, so the remaining phases cannot change it.
    logic w_any_swap;
    logic r_quiet;
    assign w_any_swap = |w_swap;
    assign w_exit     = !w_any_swap && r_quiet;
`else
    assign w_exit = 1'b0;
`endif

    // Control FSM and data buffer; every output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_buf       <= '0;
            r_phase     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
            r_quiet     <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_in_ready && bus.in_valid) begin
                        r_buf      <= bus.in_data;
                        r_phase    <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= c_ST_SORT;
`ifdef SORT_EARLY_EXIT_EN
                        r_quiet    <= 1'b0;
`endif
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                c_ST_SORT: begin
                    r_buf   <= w_next;
                    r_phase <= r_phase + 1'b1;
`ifdef SORT_EARLY_EXIT_EN
                    r_quiet <= !w_any_swap;
`endif
                    if ((r_phase == c_LAST) || w_exit) begin
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    // in_ready is raised by IDLE one cycle later.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_buf;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sort_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sort_sequencer
//  Description : Scoreboard bench for sort_sequencer (NUM_VALS=8, SIZE=8).
//                Stimulus pushes the expected sorted vector when a vector is
//                accepted; a monitor pops and compares on every output
//                handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sort_sequencer;

    localparam int c_N = 8;
    localparam int c_S = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   t_acc = 0;
    logic [63:0] sb [$];

    sort_sequencer_if #(.NUM_VALS(c_N), .SIZE(c_S)) bus ();

    sort_sequencer #(.NUM_VALS(c_N), .SIZE(c_S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_timeout(input string name);
        n_chk++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    function automatic logic [63:0] mk8(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // Reference: insertion sort, descending, lane 0 largest.
    function automatic logic [63:0] ref_sort(input logic [63:0] v);
        logic [7:0] a [8];
        logic [7:0] t;
        logic [63:0] r;
        for (int i = 0; i < 8; i++) a[i] = v[i*8 +: 8];
        for (int i = 1; i < 8; i++) begin
            t = a[i];
            for (int j = i; j > 0; j--) begin
                if (a[j-1] < t) begin
                    a[j] = a[j-1];
                    a[j-1] = t;
                end
            end
        end
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i];
        return r;
    endfunction

    // Called just after a rising edge. Returns once the vector is accepted,
    // with t_acc set to the accepting edge number.
    task automatic send(input logic [63:0] v, input logic [63:0] e);
        bit ok;
        ok = 0;
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            sb.push_back(e);
            @(posedge clk);
            #1;
            t_acc = cyc;
        end else begin
            fail_timeout("send");
        end
        bus.in_valid = 1'b0;
    endtask

    // A register updated at edge E is first seen at the negedge where
    // cyc == E, so latency is counted in edges after the accepting edge.
    task automatic wait_valid(output int lat, output int nbusy);
        bit ok;
        ok = 0;
        nbusy = 0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1;
                break;
            end
            if (bus.busy) nbusy++;
        end
        if (ok) lat = cyc - t_acc;
        else fail_timeout("wait_valid");
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_timeout(name);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the oldest expected vector.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL out_unexpected: got %h with no vector pending", bus.out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", bus.out_data, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nb;
        int exp_lat_desc;
        logic [63:0] v;
        logic [63:0] held;
        bit done;

`ifdef SORT_EARLY_EXIT_EN
        exp_lat_desc = 2;
`else
        exp_lat_desc = c_N;
`endif
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset: in_ready low during the reset cycle, high once in IDLE.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        @(negedge clk);
        chk("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Reversal needs the full phase count.
        send(mk8(1, 2, 3, 4, 5, 6, 7, 8), mk8(8, 7, 6, 5, 4, 3, 2, 1));
        wait_valid(lat, nb);
        chk("asc_latency", 64'(lat), 64'(c_N));
        chk("asc_busy_cycles", 64'(nb), 64'(c_N));
        drain("asc_drain");

        // Duplicates and extremes.
        send(mk8(200, 200, 3, 3, 255, 0, 17, 17), mk8(255, 200, 200, 17, 17, 3, 3, 0));
        drain("dup_drain");

        // Already descending.
        send(mk8(9, 8, 7, 6, 5, 4, 3, 2), mk8(9, 8, 7, 6, 5, 4, 3, 2));
        wait_valid(lat, nb);
        chk("desc_latency", 64'(lat), 64'(exp_lat_desc));
        drain("desc_drain");

        // All ones and all zeros.
        send({64{1'b1}}, {64{1'b1}});
        drain("ones_drain");
        send(64'd0, 64'd0);
        drain("zeros_drain");

        // Back-pressure: result held for 5 cycles, second vector waits.
        bus.out_ready = 1'b0;
        send(mk8(4, 90, 1, 33, 33, 250, 7, 60), mk8(250, 90, 60, 33, 33, 7, 4, 1));
        wait_valid(lat, nb);
        held = mk8(250, 90, 60, 33, 33, 7, 4, 1);
        @(posedge clk);
        #1;
        bus.in_data  = mk8(5, 6, 0, 0, 0, 0, 0, 1);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_data", bus.out_data, held);
            chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("turn_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("turn_valid", {63'd0, bus.out_valid}, 64'd0);
        @(negedge clk);
        chk("turn_in_ready2", {63'd0, bus.in_ready}, 64'd1);
        sb.push_back(mk8(6, 5, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("turn_accept_busy", {63'd0, bus.busy}, 64'd1);
        bus.in_valid = 1'b0;
        drain("bp_drain");

        // Reset in the middle of a sort discards the result.
        send(mk8(3, 1, 4, 1, 5, 9, 2, 6), mk8(9, 6, 5, 4, 3, 2, 1, 1));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("abort_out_data", bus.out_data, 64'd0);
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_in_ready", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk);
        #1;
        send(mk8(0, 0, 0, 0, 0, 0, 0, 255), mk8(255, 0, 0, 0, 0, 0, 0, 0));
        drain("abort_drain");

        // Random vectors under random back-pressure.
        done = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    for (int l = 0; l < 8; l++)
                        v[l*8 +: 8] = (i % 2 == 1) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 7));
                    send(v, ref_sort(v));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain("rand_drain");
        chk("rand_pending", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
